if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Sits directly upstream of the IF/ID register.
- Consumes ST_if_id_en and ST_br_stall from the stall unit, and the branch redirect from EX.
- Drives a single-outstanding, in-order request/response port to instruction memory.
- Presents one fetched instruction at a time to IF/ID with a valid bit; bubbles carry IF_valid=0.

Parameters:
- XLEN, 32, address/PC width in bits.
- INSN_W, 32, instruction width in bits.
- RESET_PC, 0, PC loaded on reset.
- NOP_INSN, 32'h0000_0013, IR value driven when no instruction is held.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- ST_if_id_en  in  1  IF/ID load enable from stall unit.
- ST_br_stall  in  1  branch in ID, outcome unresolved.
- EX_take_branch  in  1  redirect request from EX.
- EX_target_pc  in  XLEN  redirect target.
- IF_mem_req  out  1  fetch request valid.
- IF_mem_addr  out  XLEN  fetch address, low 2 bits always 0.
- mem_gnt  in  1  request accepted this cycle (meaningful only with IF_mem_req).
- mem_rvalid  in  1  response valid.
- mem_rdata  in  INSN_W  response instruction.
- IF_valid  out  1  IF_IR/IF_PC/IF_NPC hold a real instruction.
- IF_IR  out  INSN_W  fetched instruction.
- IF_PC  out  XLEN  address of IF_IR.
- IF_NPC  out  XLEN  IF_PC+4.

Behaviour:
- Registers: pc (next fetch address), state, IR, IF_PC, IF_NPC.
- Reset (rst=0 at edge):
  - pc=RESET_PC & ~3; state=FETCH.
  - IF_IR=NOP_INSN; IF_PC=IF_NPC=0.
  - During any cycle with rst=0, IF_mem_req=0 and IF_valid=0.
  - Reset mid-transaction: outstanding request abandoned; a later mem_rvalid is ignored because state is FETCH.
- States:
  - FETCH: no request outstanding, nothing held.
  - WAIT: one request outstanding.
  - HOLD: instruction captured, awaiting transfer.
  - SQUASH: outstanding response must be discarded.
- Combinational outputs:
  - transfer = (state==HOLD) & IF_valid & ST_if_id_en.
  - IF_valid = (state==HOLD) & ~ST_br_stall.
  - IF_mem_req = ((state==FETCH) | transfer) & ~ST_br_stall & ~EX_take_branch.
  - IF_mem_addr = pc.
- Redirect has highest priority in every state.
  - pc <= {EX_target_pc[XLEN-1:2],2'b00}; held instruction discarded.
  - Next state: FETCH if state is FETCH or HOLD, or if state is WAIT with mem_rvalid the same cycle.
  - Next state: SQUASH if state is WAIT without mem_rvalid, or if state is SQUASH without mem_rvalid.
  - SQUASH with mem_rvalid: discard, go to FETCH.
- FETCH:
  - IF_mem_req & mem_gnt -> WAIT.
  - Otherwise stay (including while ST_br_stall=1).
- WAIT:
  - mem_rvalid -> capture: IR<=mem_rdata, IF_PC<=pc, IF_NPC<=pc+4, pc<=pc+4; -> HOLD.
  - Otherwise stay.
- HOLD:
  - ST_br_stall=1 -> instruction retained, presented as bubble (IF_valid=0), stay.
  - ST_br_stall=0 & ST_if_id_en=0 -> outputs held stable, stay.
  - transfer & mem_gnt -> WAIT.
  - transfer & ~mem_gnt -> FETCH.
- SQUASH:
  - mem_rvalid -> drop data, -> FETCH.
  - No request is issued in SQUASH.
- IR reads NOP_INSN whenever state!=HOLD.
- mem_rvalid in FETCH or HOLD is ignored.
- PC arithmetic is modulo 2^XLEN: pc=FFFF_FFFC increments to 0.
- Best-case throughput is one instruction per 2 cycles with 1-cycle memory latency.

Test Plan:
- Reset, then 1-cycle memory with gnt=1, ST_if_id_en=1 -> requests at 0,4,8; IF_valid pulses with IF_PC=0,4,8 every 2nd cycle, IF_NPC=IF_PC+4.
- Hold ST_if_id_en=0 for 3 cycles while in HOLD at PC 0x8 -> IF_IR/IF_PC stable, IF_mem_req=0; release -> transfer, next request at 0xC.
- ST_br_stall=1 while holding PC 0x10, then EX_take_branch with target 0x103 -> IF_valid=0 throughout, held instruction dropped, next request at 0x100.
- Redirect to 0x40 in WAIT, response arrives 2 cycles later with 0xDEAD_BEEF -> response discarded (never valid), next request at 0x40.
- pc=0xFFFF_FFFC fetched -> IF_NPC=0, next request at 0x0; redirect coincident with mem_rvalid -> data dropped, state FETCH.
- Assert rst=0 during WAIT, stray mem_rvalid after release -> ignored, first request at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Single-outstanding in-order fetch with stall, hold and redirect squash.
module if_fetch_unit #(
  parameter int                XLEN     = 32,
  parameter int                INSN_W   = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [INSN_W-1:0] NOP_INSN = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ST_if_id_en,
  input  logic              ST_br_stall,
  input  logic              EX_take_branch,
  input  logic [XLEN-1:0]   EX_target_pc,
  output logic              IF_mem_req,
  output logic [XLEN-1:0]   IF_mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INSN_W-1:0] mem_rdata,
  output logic              IF_valid,
  output logic [INSN_W-1:0] IF_IR,
  output logic [XLEN-1:0]   IF_PC,
  output logic [XLEN-1:0]   IF_NPC
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_SQUASH
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_pc;
  logic [INSN_W-1:0] r_ir;
  logic [XLEN-1:0]   r_if_pc;
  logic [XLEN-1:0]   r_if_npc;
  logic [XLEN-1:0]   w_pc_inc;
  logic [XLEN-1:0]   w_target;
  logic              w_valid;
  logic              w_transfer;
  logic              w_req;
  logic              w_capture;
  logic              w_unused;

  assign w_pc_inc  = r_pc + {{(XLEN-3){1'b0}}, 3'd4};
  assign w_target  = {EX_target_pc[XLEN-1:2], 2'b00};
  assign w_capture = (r_state == S_WAIT) & mem_rvalid;
  assign w_unused  = ^EX_target_pc[1:0];

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Next-state logic; redirect overrides every state.
  always_comb begin
    w_next = r_state;
    if (EX_take_branch) begin
      unique case (r_state)
        S_FETCH, S_HOLD: w_next = S_FETCH;
        S_WAIT, S_SQUASH:
          w_next = mem_rvalid ? S_FETCH : S_SQUASH;
        default: w_next = S_FETCH;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH:
          if (w_req & mem_gnt) w_next = S_WAIT;
        S_WAIT:
          if (mem_rvalid) w_next = S_HOLD;
        S_HOLD:
          if (w_transfer)
            w_next = mem_gnt ? S_WAIT : S_FETCH;
        S_SQUASH:
          if (mem_rvalid) w_next = S_FETCH;
        default: w_next = S_FETCH;
      endcase
    end
  end

  // Output decode; nothing is requested or presented while in reset.
  always_comb begin
    w_valid    = rst & (r_state == S_HOLD) & ~ST_br_stall;
    w_transfer = (r_state == S_HOLD) & w_valid & ST_if_id_en;
    w_req      = rst & ((r_state == S_FETCH) | w_transfer)
               & ~ST_br_stall & ~EX_take_branch;
    IF_IR      = (r_state == S_HOLD) ? r_ir : NOP_INSN;
  end

  // Fetch PC and captured instruction bundle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
      r_ir     <= NOP_INSN;
      r_if_pc  <= '0;
      r_if_npc <= '0;
    end else if (EX_take_branch) begin
      r_pc <= w_target;
    end else if (w_capture) begin
      r_ir     <= mem_rdata;
      r_if_pc  <= r_pc;
      r_if_npc <= w_pc_inc;
      r_pc     <= w_pc_inc;
    end
  end

  assign IF_mem_req  = w_req;
  assign IF_mem_addr = r_pc;
  assign IF_valid    = w_valid;
  assign IF_PC       = r_if_pc;
  assign IF_NPC      = r_if_npc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit.
// Each scenario task drives inputs and checks outputs inline.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ST_if_id_en;
  logic        ST_br_stall;
  logic        EX_take_branch;
  logic [31:0] EX_target_pc;
  logic        IF_mem_req;
  logic [31:0] IF_mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        IF_valid;
  logic [31:0] IF_IR;
  logic [31:0] IF_PC;
  logic [31:0] IF_NPC;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ST_if_id_en    (ST_if_id_en),
    .ST_br_stall    (ST_br_stall),
    .EX_take_branch (EX_take_branch),
    .EX_target_pc   (EX_target_pc),
    .IF_mem_req     (IF_mem_req),
    .IF_mem_addr    (IF_mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .IF_valid       (IF_valid),
    .IF_IR          (IF_IR),
    .IF_PC          (IF_PC),
    .IF_NPC         (IF_NPC)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Grant the pending request, then return data one cycle later.
  task automatic issue(input logic [31:0] data);
    mem_gnt = 1'b1;
    cyc();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = data;
    cyc();
    mem_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ST_if_id_en = 1'b1;
    ST_br_stall = 1'b0;
    EX_take_branch = 1'b0;
    EX_target_pc = '0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    cyc();
    cyc();
    checks++;
    if (IF_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got %b want 0", IF_mem_req);
    end
    checks++;
    if (IF_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b want 0", IF_valid);
    end
    checks++;
    if (IF_IR !== NOP) begin
      errors++;
      $display("FAIL rst_ir got %h want %h", IF_IR, NOP);
    end
    checks++;
    if (IF_PC !== 32'h0 || IF_NPC !== 32'h0) begin
      errors++;
      $display("FAIL rst_pc got %h/%h want 0/0", IF_PC, IF_NPC);
    end
    rst = 1'b1;
    #1;
  endtask

  task automatic test_stream();
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL s_req0 got %b/%h want 1/0", IF_mem_req, IF_mem_addr);
    end
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    checks++;
    if (IF_valid !== 1'b0 || IF_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL s_wait got %b/%b want 0/0", IF_valid, IF_mem_req);
    end
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0010_0093;
    cyc();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (IF_valid !== 1'b1 || IF_IR !== 32'h0010_0093) begin
      errors++;
      $display("FAIL s_v0 got %b/%h want 1/00100093", IF_valid, IF_IR);
    end
    checks++;
    if (IF_PC !== 32'h0 || IF_NPC !== 32'h4) begin
      errors++;
      $display("FAIL s_pc0 got %h/%h want 0/4", IF_PC, IF_NPC);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h4) begin
      errors++;
      $display("FAIL s_req4 got %b/%h want 1/4", IF_mem_req, IF_mem_addr);
    end
    issue(32'h0020_0113);
    checks++;
    if (IF_valid !== 1'b1 || IF_PC !== 32'h4 || IF_NPC !== 32'h8) begin
      errors++;
      $display("FAIL s_pc4 got %b/%h/%h want 1/4/8", IF_valid, IF_PC, IF_NPC);
    end
    checks++;
    if (IF_mem_addr !== 32'h8) begin
      errors++;
      $display("FAIL s_req8 got %h want 8", IF_mem_addr);
    end
    issue(32'h0030_0193);
    checks++;
    if (IF_PC !== 32'h8 || IF_IR !== 32'h0030_0193) begin
      errors++;
      $display("FAIL s_pc8 got %h/%h want 8/00300193", IF_PC, IF_IR);
    end
  endtask

  task automatic test_hold_en();
    ST_if_id_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (IF_mem_req !== 1'b0 || IF_PC !== 32'h8 ||
          IF_IR !== 32'h0030_0193 || IF_valid !== 1'b1) begin
        errors++;
        $display("FAIL hold_%0d got %b/%h/%h/%b want 0/8/00300193/1",
                 i, IF_mem_req, IF_PC, IF_IR, IF_valid);
      end
      cyc();
    end
    ST_if_id_en = 1'b1;
    #1;
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'hC) begin
      errors++;
      $display("FAIL hold_rel got %b/%h want 1/c", IF_mem_req, IF_mem_addr);
    end
    issue(32'h0040_0213);
    checks++;
    if (IF_PC !== 32'hC || IF_NPC !== 32'h10) begin
      errors++;
      $display("FAIL hold_c got %h/%h want c/10", IF_PC, IF_NPC);
    end
    issue(32'h0050_0293);
    checks++;
    if (IF_valid !== 1'b1 || IF_PC !== 32'h10) begin
      errors++;
      $display("FAIL hold_10 got %b/%h want 1/10", IF_valid, IF_PC);
    end
  endtask

  task automatic test_br_stall();
    ST_br_stall = 1'b1;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bs_0 got %b/%b want 0/0", IF_valid, IF_mem_req);
    end
    cyc();
    EX_take_branch = 1'b1;
    EX_target_pc = 32'h0000_0103;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL bs_1 got %b/%b want 0/0", IF_valid, IF_mem_req);
    end
    cyc();
    EX_take_branch = 1'b0;
    ST_br_stall = 1'b0;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_IR !== NOP) begin
      errors++;
      $display("FAIL bs_drop got %b/%h want 0/%h", IF_valid, IF_IR, NOP);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL bs_req got %b/%h want 1/100", IF_mem_req, IF_mem_addr);
    end
  endtask

  task automatic test_squash();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    EX_take_branch = 1'b1;
    EX_target_pc = 32'h0000_0040;
    #1;
    checks++;
    if (IF_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sq_br got %b want 0", IF_mem_req);
    end
    cyc();
    EX_take_branch = 1'b0;
    #1;
    checks++;
    if (IF_mem_req !== 1'b0 || IF_valid !== 1'b0) begin
      errors++;
      $display("FAIL sq_wait got %b/%b want 0/0", IF_mem_req, IF_valid);
    end
    cyc();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (IF_mem_req !== 1'b0 || IF_valid !== 1'b0) begin
      errors++;
      $display("FAIL sq_rsp got %b/%b want 0/0", IF_mem_req, IF_valid);
    end
    cyc();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_IR !== NOP) begin
      errors++;
      $display("FAIL sq_drop got %b/%h want 0/%h", IF_valid, IF_IR, NOP);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL sq_req got %b/%h want 1/40", IF_mem_req, IF_mem_addr);
    end
  endtask

  task automatic test_wrap();
    EX_take_branch = 1'b1;
    EX_target_pc = 32'hFFFF_FFFF;
    cyc();
    EX_take_branch = 1'b0;
    #1;
    checks++;
    if (IF_mem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wr_addr got %h want fffffffc", IF_mem_addr);
    end
    issue(32'h0060_0313);
    checks++;
    if (IF_PC !== 32'hFFFF_FFFC || IF_NPC !== 32'h0) begin
      errors++;
      $display("FAIL wr_npc got %h/%h want fffffffc/0", IF_PC, IF_NPC);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wr_req got %b/%h want 1/0", IF_mem_req, IF_mem_addr);
    end
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h1234_5678;
    EX_take_branch = 1'b1;
    EX_target_pc = 32'h0000_0080;
    cyc();
    mem_rvalid = 1'b0;
    EX_take_branch = 1'b0;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_IR !== NOP) begin
      errors++;
      $display("FAIL wr_coin got %b/%h want 0/%h", IF_valid, IF_IR, NOP);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL wr_fetch got %b/%h want 1/80", IF_mem_req, IF_mem_addr);
    end
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1;
    cyc();
    mem_gnt = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (IF_mem_req !== 1'b0 || IF_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_rst got %b/%b want 0/0", IF_mem_req, IF_valid);
    end
    cyc();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_req got %b/%h want 1/0", IF_mem_req, IF_mem_addr);
    end
    cyc();
    mem_rvalid = 1'b0;
    #1;
    checks++;
    if (IF_valid !== 1'b0 || IF_IR !== NOP) begin
      errors++;
      $display("FAIL rm_stray got %b/%h want 0/%h", IF_valid, IF_IR, NOP);
    end
    checks++;
    if (IF_mem_req !== 1'b1 || IF_mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rm_fetch got %b/%h want 1/0", IF_mem_req, IF_mem_addr);
    end
    issue(32'h0070_0393);
    checks++;
    if (IF_valid !== 1'b1 || IF_PC !== 32'h0 || IF_IR !== 32'h0070_0393) begin
      errors++;
      $display("FAIL rm_first got %b/%h/%h want 1/0/00700393",
               IF_valid, IF_PC, IF_IR);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hold_en();
    test_br_stall();
    test_squash();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
